// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One radix-2 step per cycle in CALC (shift-add multiply or restoring divide
// on operand magnitudes), sign correction and result select in FIX, and a
// single-cycle completion pulse in DONE. Divide-by-zero and signed overflow
// bypass the iteration and complete straight from IDLE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd,
  output logic            wb_en
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [2:0]          op_reg, op_next;
  logic [4:0]          rd_reg, rd_next;
  logic [XLEN-1:0]     mag_a_reg, mag_a_next;
  logic [XLEN-1:0]     mag_b_reg, mag_b_next;
  logic                sign_a_reg, sign_a_next;
  logic                sign_b_reg, sign_b_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;
  logic [XLEN-1:0]     result_reg, result_next;
  logic [4:0]          wb_rd_reg, wb_rd_next;

  // Operand decode on the incoming request: which operands are signed,
  // their sign flags and magnitudes.
  logic            in_is_div;
  logic            in_a_signed;
  logic            in_b_signed;
  logic            in_sign_a;
  logic            in_sign_b;
  logic [XLEN-1:0] in_mag_a;
  logic [XLEN-1:0] in_mag_b;
  logic            in_div_zero;
  logic            in_overflow;

  assign in_is_div   = op[2];
  // DIV/REM have op[0]=0; among the multiplies only MULHU treats a as unsigned
  // and only MUL/MULH treat b as signed.
  assign in_a_signed = in_is_div ? ~op[0] : (op != 3'b011);
  assign in_b_signed = in_is_div ? ~op[0] : ~op[1];
  assign in_sign_a   = in_a_signed & rs1_val[XLEN-1];
  assign in_sign_b   = in_b_signed & rs2_val[XLEN-1];
  assign in_mag_a    = in_sign_a ? (~rs1_val + XLEN'(1)) : rs1_val;
  assign in_mag_b    = in_sign_b ? (~rs2_val + XLEN'(1)) : rs2_val;
  assign in_div_zero = in_is_div && (rs2_val == '0);
  assign in_overflow = in_is_div && ~op[0] &&
                       (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (rs2_val == {XLEN{1'b1}});

  // Datapath for one iteration step. For multiply the accumulator holds
  // {partial high, remaining multiplier bits}; for divide it holds
  // {partial remainder, dividend bits being shifted into quotient}.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot_fixed;
  logic [XLEN-1:0]   rem_fixed;

  assign mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                      {1'b0, (acc_reg[0] ? mag_a_reg : {XLEN{1'b0}})};
  assign div_shift  = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, mag_b_reg};
  assign prod_fixed = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + (2*XLEN)'(1)) : acc_reg;
  assign quot_fixed = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[XLEN-1:0] + XLEN'(1))
                                                : acc_reg[XLEN-1:0];
  assign rem_fixed  = sign_a_reg ? (~acc_reg[2*XLEN-1:XLEN] + XLEN'(1))
                                 : acc_reg[2*XLEN-1:XLEN];

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      rd_reg     <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      acc_reg    <= '0;
      result_reg <= '0;
      wb_rd_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      rd_reg     <= rd_next;
      mag_a_reg  <= mag_a_next;
      mag_b_reg  <= mag_b_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      wb_rd_reg  <= wb_rd_next;
    end
  end

  // Next-state and datapath update; kill overrides everything and leaves
  // the visible result/wb_rd untouched.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    rd_next     = rd_reg;
    mag_a_next  = mag_a_reg;
    mag_b_next  = mag_b_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    wb_rd_next  = wb_rd_reg;

    if (kill) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_next     = op;
            rd_next     = rd;
            mag_a_next  = in_mag_a;
            mag_b_next  = in_mag_b;
            sign_a_next = in_sign_a;
            sign_b_next = in_sign_b;
            count_next  = '0;
            if (in_div_zero) begin
              // Quotient is all ones; remainder is the raw dividend.
              result_next = op[1] ? rs1_val : {XLEN{1'b1}};
              wb_rd_next  = rd;
              state_next  = DONE;
            end else if (in_overflow) begin
              result_next = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
              wb_rd_next  = rd;
              state_next  = DONE;
            end else begin
              // Multiply starts with the multiplier in the low half;
              // divide starts with the dividend in the low half.
              acc_next   = {{XLEN{1'b0}}, (in_is_div ? in_mag_a : in_mag_b)};
              state_next = CALC;
            end
          end
        end

        CALC: begin
          if (!op_reg[2]) begin
            acc_next = {mul_sum, acc_reg[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            acc_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
          end else begin
            acc_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
          end
          count_next = count_reg + CW'(1);
          if (count_reg == CW'(XLEN-1)) begin
            state_next = FIX;
          end
        end

        FIX: begin
          if (op_reg == OP_MUL) begin
            result_next = prod_fixed[XLEN-1:0];
          end else if (!op_reg[2]) begin
            result_next = prod_fixed[2*XLEN-1:XLEN];
          end else if (!op_reg[1]) begin
            result_next = quot_fixed;
          end else begin
            result_next = rem_fixed;
          end
          wb_rd_next = rd_reg;
          state_next = DONE;
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign wb_rd  = wb_rd_reg;
  assign wb_en  = done && (wb_rd_reg != 5'd0);

endmodule
